// File: rtl/hc595_pkg.sv
// Shared types and constants for the 74HC595 chain receiver.
// Holds the receiver FSM encoding and the bit-counter width/limit.
// Optional cascade outputs are enabled by defining HC595_CASCADE_EN.
package hc595_pkg;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    IDLE   = 2'd1,
    SHIFT  = 2'd2
  } state_t;

  localparam int BIT_CNT_W   = 5;
  localparam int BIT_CNT_MAX = 31;

endpackage

// File: rtl/hc595_sync_edge.sv
// Multi-flop synchronizer for one bus line with a rising-edge pulse.
// Latency: level appears SYNC_STAGES cycles after the pin; rise pulses one
// cycle when the last stage goes high while the history flop is still low.
module hc595_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;

  // Synchronizer chain plus one history flop behind the last stage
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      hist <= sync[SYNC_STAGES-1];
    end
  end

  assign level = sync[SYNC_STAGES-1];
  assign rise  = sync[SYNC_STAGES-1] & ~hist;

endmodule

// File: rtl/hc595_chain_receiver.sv
// Receiver for a two-chip 74HC595 serial display bus (DIO/SRCLK/RCLK).
// Latency: pin edge to register update is SYNC_STAGES+1 Clk cycles.
// No backpressure: the bus is sampled free-running; HC595_CASCADE_EN adds QH_OUT and Overflow.
module hc595_chain_receiver
  import hc595_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   DIO,
  input  logic                   SRCLK,
  input  logic                   RCLK,
  output logic [WIDTH/2-1:0]     SEG,
  output logic [WIDTH/2-1:0]     SEL,
  output logic                   Frame_Valid,
  output logic                   Frame_Err,
  output logic [BIT_CNT_W-1:0]   Bit_Cnt
`ifdef HC595_CASCADE_EN
  ,
  output logic                   QH_OUT,
  output logic                   Overflow
`endif
);

  localparam int WARM_W = $clog2(SYNC_STAGES + 2);

  logic dio_lvl, dio_rise;
  logic srclk_lvl, srclk_rise;
  logic rclk_lvl, rclk_rise;
  logic unused_sync;

  // DIO shares the synchronizer depth so its level lines up with the SRCLK rise.
  hc595_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dio (
    .clk   (Clk),
    .reset (Reset),
    .din   (DIO),
    .level (dio_lvl),
    .rise  (dio_rise)
  );

  hc595_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_srclk (
    .clk   (Clk),
    .reset (Reset),
    .din   (SRCLK),
    .level (srclk_lvl),
    .rise  (srclk_rise)
  );

  hc595_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rclk (
    .clk   (Clk),
    .reset (Reset),
    .din   (RCLK),
    .level (rclk_lvl),
    .rise  (rclk_rise)
  );

  assign unused_sync = ^{dio_rise, srclk_lvl, rclk_lvl};

  state_t              state, state_nxt;
  logic [WARM_W-1:0]   warm_cnt;
  logic                shift_en;
  logic                latch_en;
  logic [WIDTH-1:0]    shift_reg;

  // State register and warm-up timer; edges are ignored until history flops settle
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= WARMUP;
      warm_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == WARMUP) begin
        warm_cnt <= warm_cnt + WARM_W'(1);
      end
    end
  end

  // Next-state: a shift always leaves us in SHIFT, even alongside a latch,
  // because the concurrent bit belongs to the new frame.
  always_comb begin
    state_nxt = state;
    case (state)
      WARMUP: begin
        if (warm_cnt == WARM_W'(SYNC_STAGES)) begin
          state_nxt = IDLE;
        end
      end
      IDLE, SHIFT: begin
        if (srclk_rise) begin
          state_nxt = SHIFT;
        end else if (rclk_rise) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = WARMUP;
    endcase
  end

  // Output decode: bus edges only act once warm-up has finished
  always_comb begin
    shift_en = 1'b0;
    latch_en = 1'b0;
    case (state)
      IDLE, SHIFT: begin
        shift_en = srclk_rise;
        latch_en = rclk_rise;
      end
      default: begin
        shift_en = 1'b0;
        latch_en = 1'b0;
      end
    endcase
  end

  // Shift register: MSB-first, oldest bits fall off the top on overlength frames
  always_ff @(posedge Clk) begin
    if (Reset) begin
      shift_reg <= '0;
    end else if (shift_en) begin
      shift_reg <= {shift_reg[WIDTH-2:0], dio_lvl};
    end
  end

  // Storage latch and bit counter; the latch sees the pre-shift register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      SEG         <= '0;
      SEL         <= '0;
      Frame_Valid <= 1'b0;
      Frame_Err   <= 1'b0;
      Bit_Cnt     <= '0;
    end else begin
      Frame_Valid <= 1'b0;
      Frame_Err   <= 1'b0;
      if (latch_en) begin
        {SEG, SEL}  <= shift_reg;
        Frame_Valid <= 1'b1;
        Frame_Err   <= (Bit_Cnt != BIT_CNT_W'(WIDTH));
        Bit_Cnt     <= shift_en ? BIT_CNT_W'(1) : '0;
      end else if (shift_en) begin
        if (Bit_Cnt != BIT_CNT_W'(BIT_CNT_MAX)) begin
          Bit_Cnt <= Bit_Cnt + BIT_CNT_W'(1);
        end
      end
    end
  end

`ifdef HC595_CASCADE_EN
  // QH' mirror is the shift register MSB, which is itself a flop
  assign QH_OUT = shift_reg[WIDTH-1];

  // Sticky overflow once more than WIDTH bits arrive; a latch clears it
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Overflow <= 1'b0;
    end else if (latch_en) begin
      Overflow <= 1'b0;
    end else if (shift_en && (Bit_Cnt >= BIT_CNT_W'(WIDTH))) begin
      Overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hc595_chain_receiver.sv
// Scoreboard bench for hc595_chain_receiver: stimulus pushes expected frames,
// a negedge monitor pops and compares on every Frame_Valid pulse.
// Direct checks cover reset state, Bit_Cnt values and the cascade option.
module tb_hc595_chain_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dio = 1'b0;
  logic       srclk = 1'b0;
  logic       rclk = 1'b0;
  logic [7:0] seg, sel;
  logic       fvld, ferr;
  logic [4:0] bcnt;
`ifdef HC595_CASCADE_EN
  logic       qh_out, ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [7:0] seg;
    logic [7:0] sel;
    logic       err;
    logic [4:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  hc595_chain_receiver #(.WIDTH(16), .SYNC_STAGES(2)) dut (
    .Clk         (clk),
    .Reset       (rst),
    .DIO         (dio),
    .SRCLK       (srclk),
    .RCLK        (rclk),
    .SEG         (seg),
    .SEL         (sel),
    .Frame_Valid (fvld),
    .Frame_Err   (ferr),
    .Bit_Cnt     (bcnt)
`ifdef HC595_CASCADE_EN
    ,
    .QH_OUT      (qh_out),
    .Overflow    (ovf)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every Frame_Valid pulse must match the oldest expected frame
  always @(negedge clk) begin
    if (!rst && fvld) begin
      exp_t got, want;
      got = '{seg: seg, sel: sel, err: ferr, cnt: bcnt};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL frame_unexpected: got seg=%h sel=%h err=%b cnt=%0d, expected no frame",
                 seg, sel, ferr, bcnt);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_bad++;
          $display("FAIL frame: got seg=%h sel=%h err=%b cnt=%0d, expected seg=%h sel=%h err=%b cnt=%0d",
                   got.seg, got.sel, got.err, got.cnt, want.seg, want.sel, want.err, want.cnt);
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    dio = b;
    wait_clk(3);
    srclk = 1'b1;
    wait_clk(4);
    srclk = 1'b0;
    wait_clk(4);
  endtask

  // Sends the low n bits of v, most significant first
  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic pulse_rclk();
    rclk = 1'b1;
    wait_clk(4);
    rclk = 1'b0;
    wait_clk(6);
  endtask

  task automatic push(input logic [15:0] v, input logic err, input logic [4:0] cnt);
    exp_q.push_back('{seg: v[15:8], sel: v[7:0], err: err, cnt: cnt});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with SRCLK already high: no edge must be seen after warm-up
    srclk = 1'b1;
    rst   = 1'b1;
    wait_clk(3);
    check("reset_seg", 32'(seg), 32'h0);
    check("reset_sel", 32'(sel), 32'h0);
    check("reset_valid", 32'(fvld), 32'h0);
    check("reset_err", 32'(ferr), 32'h0);
    check("reset_bitcnt", 32'(bcnt), 32'h0);
    rst = 1'b0;
    wait_clk(20);
    check("srclk_high_at_release_bitcnt", 32'(bcnt), 32'h0);
    srclk = 1'b0;
    wait_clk(6);
    check("srclk_fall_bitcnt", 32'(bcnt), 32'h0);

    // Driver-equivalent frame SEG=EE, SEL=2E
    send_bits(32'hEE2E, 16);
    check("full_frame_bitcnt", 32'(bcnt), 32'd16);
    push(16'hEE2E, 1'b0, 5'd0);
    pulse_rclk();
    check("after_latch_bitcnt", 32'(bcnt), 32'd0);

    // Short frame: previous LSB (0) slides to the MSB above 15 new bits
    send_bits(32'h5A5A, 15);
    push(16'h5A5A, 1'b1, 5'd0);
    pulse_rclk();

    // Overlength frame: leading 1 of 0x1A55A falls off
    send_bits(32'h1A55A, 17);
    check("overlength_bitcnt", 32'(bcnt), 32'd17);
    push(16'hA55A, 1'b1, 5'd0);
    pulse_rclk();

    // Zero-bit latch re-latches stale data
    push(16'hA55A, 1'b1, 5'd0);
    pulse_rclk();

    // Simultaneous SRCLK/RCLK rise after 0x1234 with DIO=1
    send_bits(32'h1234, 16);
    dio = 1'b1;
    wait_clk(3);
    push(16'h1234, 1'b0, 5'd1);
    srclk = 1'b1;
    rclk  = 1'b1;
    wait_clk(4);
    srclk = 1'b0;
    rclk  = 1'b0;
    wait_clk(6);
    check("simul_bitcnt", 32'(bcnt), 32'd1);
    // That lone bit is now a one-bit frame: 0x1234<<1 | 1
    push(16'h2469, 1'b1, 5'd0);
    pulse_rclk();

    // Saturation: 33 ones pin Bit_Cnt at 31
    send_bits(32'hFFFF_FFFF, 32);
    send_bit(1'b1);
    check("saturate_bitcnt", 32'(bcnt), 32'd31);
    push(16'hFFFF, 1'b1, 5'd0);
    pulse_rclk();

    // Reset mid-frame discards the partial byte
    send_bits(32'hFF, 8);
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(6);
    check("midreset_seg", 32'(seg), 32'h0);
    check("midreset_sel", 32'(sel), 32'h0);
    check("midreset_bitcnt", 32'(bcnt), 32'h0);
    send_bits(32'h00FF, 16);
    push(16'h00FF, 1'b0, 5'd0);
    pulse_rclk();

`ifdef HC595_CASCADE_EN
    send_bits(32'h8000, 16);
    check("cascade_qh_after16", 32'(qh_out), 32'h1);
    check("cascade_ovf_at16", 32'(ovf), 32'h0);
    send_bit(1'b0);
    check("cascade_qh_after17", 32'(qh_out), 32'h0);
    check("cascade_ovf_at17", 32'(ovf), 32'h1);
    send_bits(32'h0, 15);
    push(16'h0000, 1'b1, 5'd0);
    pulse_rclk();
    check("cascade_ovf_cleared", 32'(ovf), 32'h0);
`endif

    wait_clk(10);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
